wb_arbiter: RTL

//  Writeback stage of the dual-issue RISu64 core. Merges results from two fixed-latency

---
 rtl/wb_arbiter_pkg.sv | 26 ++
 rtl/wb_rr_arb.sv | 56 +++++
 rtl/wb_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// wb_arbiter_pkg
// Shared widths, register constants and slot-source encoding for writeback.
// Revision: 1.0
// ============================================================================
package wb_arbiter_pkg;

    localparam int WB_XLEN   = 64;
    localparam int RF_WPORTS = 2;
    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int LL_REQS = 2;
    localparam int REQ_LSU = 0;
    localparam int REQ_MD  = 1;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_IP0  = 3'd1,
        SRC_IP1  = 3'd2,
        SRC_LSU  = 3'd3,
        SRC_MD   = 3'd4
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_rr_arb.sv
`default_nettype none
// ============================================================================
// wb_rr_arb
// Two-requestor (LSU/MD) slot arbiter. Round-robin when WB_RR_EN is defined,
// fixed priority LSU > MD otherwise.
// Revision: 1.0
// ============================================================================
module wb_rr_arb
    import wb_arbiter_pkg::*;
(
`ifdef WB_RR_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic [LL_REQS-1:0] i_req,
    input  logic [1:0]         i_avail,
    output logic [LL_REQS-1:0] o_gnt,
    output logic               o_md_first
);

    logic w_md_wins;
    logic w_contended;

    assign w_contended = (i_avail == 2'd1) && (&i_req);

`ifdef WB_RR_EN
    logic r_rr_ptr;

    assign w_md_wins = r_rr_ptr;

    // After a contended grant the pointer moves to the loser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_contended) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end
`else
    assign w_md_wins = 1'b0;
`endif

    always_comb begin
        o_gnt = '0;
        if (w_contended) begin
            o_gnt[REQ_MD]  = w_md_wins;
            o_gnt[REQ_LSU] = ~w_md_wins;
        end else if (i_avail != 2'd0) begin
            o_gnt = i_req;
        end
    end

    assign o_md_first = o_gnt[REQ_MD] & (~o_gnt[REQ_LSU] | w_md_wins);

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// wb_arbiter
// Writeback merge of ip0/ip1/LSU/MD onto two registered RF write ports with
// starvation stall request. Option macro: WB_RR_EN (round-robin LSU/MD).
// Revision: 1.0
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN         = WB_XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ip0_valid,
    input  logic [4:0]      ip0_dst,
    input  logic [XLEN-1:0] ip0_wdata,
    input  logic            ip1_valid,
    input  logic [4:0]      ip1_dst,
    input  logic [XLEN-1:0] ip1_wdata,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_dst,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic            md_valid,
    output logic            md_ready,
    input  logic [4:0]      md_dst,
    input  logic [XLEN-1:0] md_wdata,
    output logic            rf_wen0,
    output logic [4:0]      rf_wdst0,
    output logic [XLEN-1:0] rf_wdata0,
    output logic            rf_wen1,
    output logic [4:0]      rf_wdst1,
    output logic [XLEN-1:0] rf_wdata1,
    output logic            wb_stall_req
);

    localparam logic [1:0] c_PORTS = 2'(RF_WPORTS);
    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]         w_free;
    logic [LL_REQS-1:0] w_req;
    logic [LL_REQS-1:0] w_gnt;
    logic               w_md_first;
    wb_src_e            w_ll_a;
    wb_src_e            w_ll_b;
    wb_src_e [1:0]      w_src;
    logic [1:0]         w_sv;
    logic [1:0][4:0]    w_sd;
    logic [1:0][XLEN-1:0] w_sdat;
    logic [3:0]         w_starve_nxt;
    logic [3:0]         r_starve_cnt;

    assign w_free = c_PORTS - {1'b0, ip0_valid} - {1'b0, ip1_valid};
    assign w_req  = {md_valid, lsu_valid};

    wb_rr_arb u_arb (
`ifdef WB_RR_EN
        .clk        (clk),
        .rst        (rst),
`endif
        .i_req      (w_req),
        .i_avail    (w_free),
        .o_gnt      (w_gnt),
        .o_md_first (w_md_first)
    );

    assign lsu_ready = w_gnt[REQ_LSU] & ~rst;
    assign md_ready  = w_gnt[REQ_MD]  & ~rst;

    // Pipe results own their slot; granted LSU/MD results fill the free ones
    // in order, lower slot first.
    always_comb begin
        w_ll_a = SRC_NONE;
        w_ll_b = SRC_NONE;
        if (|w_gnt) w_ll_a = w_md_first ? SRC_MD : SRC_LSU;
        if (&w_gnt) w_ll_b = w_md_first ? SRC_LSU : SRC_MD;
        w_src[0] = ip0_valid ? SRC_IP0 : w_ll_a;
        w_src[1] = ip1_valid ? SRC_IP1 : (ip0_valid ? w_ll_a : w_ll_b);
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_sv[s]   = 1'b1;
            w_sd[s]   = REG_X0;
            w_sdat[s] = '0;
            case (w_src[s])
                SRC_IP0: begin w_sd[s] = ip0_dst; w_sdat[s] = ip0_wdata; end
                SRC_IP1: begin w_sd[s] = ip1_dst; w_sdat[s] = ip1_wdata; end
                SRC_LSU: begin w_sd[s] = lsu_dst; w_sdat[s] = lsu_wdata; end
                SRC_MD:  begin w_sd[s] = md_dst;  w_sdat[s] = md_wdata;  end
                default: w_sv[s] = 1'b0;
            endcase
        end
    end

    always_comb begin
        if (!(lsu_valid | md_valid) || (|w_gnt)) begin
            w_starve_nxt = 4'd0;
        end else if (r_starve_cnt >= c_LIMIT) begin
            w_starve_nxt = c_LIMIT;
        end else begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen0      <= 1'b0;
            rf_wdst0     <= '0;
            rf_wdata0    <= '0;
            rf_wen1      <= 1'b0;
            rf_wdst1     <= '0;
            rf_wdata1    <= '0;
            wb_stall_req <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            // x0 results are consumed but never written.
            rf_wen0      <= w_sv[0] && (w_sd[0] != REG_X0);
            rf_wdst0     <= w_sd[0];
            rf_wdata0    <= w_sdat[0];
            rf_wen1      <= w_sv[1] && (w_sd[1] != REG_X0);
            rf_wdst1     <= w_sd[1];
            rf_wdata1    <= w_sdat[1];
            wb_stall_req <= (w_starve_nxt >= c_LIMIT);
            r_starve_cnt <= w_starve_nxt;
        end
    end

    a_no_dup_dst: assert property (@(posedge clk) disable iff (rst)
        !(rf_wen0 && rf_wen1 && (rf_wdst0 == rf_wdst1)));

endmodule
`default_nettype wire
